// File: rtl/apb_gpio_irq.sv
// APB3 GPIO with per-bit direction, atomic set/clear, synchronised readback
// and sticky rising/falling edge interrupts folded into one level irq line.
module apb_gpio_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [4:0]       PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] A_DIR     = 3'd0;
  localparam logic [2:0] A_ODR     = 3'd1;
  localparam logic [2:0] A_IDR     = 3'd2;
  localparam logic [2:0] A_SET     = 3'd3;
  localparam logic [2:0] A_CLR     = 3'd4;
  localparam logic [2:0] A_RISE_EN = 3'd5;
  localparam logic [2:0] A_FALL_EN = 3'd6;
  localparam logic [2:0] A_IPR     = 3'd7;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_odr;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_ipr;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic             r_pready;
  logic             r_pslverr;
  logic [31:0]      r_prdata;

  logic [2:0]       w_idx;
  logic             w_access;
  logic             w_rd_load;
  logic             w_commit;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_idx    = PADDR[4:2];
  assign w_wdata  = PWDATA[WIDTH-1:0];
  assign w_unused = ^{PWDATA, PADDR[1:0]};

  // The first access cycle loads read data and raises PREADY; the write
  // lands on the edge that closes the PREADY=1 cycle, so a dropped PSEL
  // at any point before then leaves every register untouched.
  assign w_access  = PSEL & PENABLE;
  assign w_rd_load = w_access & ~r_pready;
  assign w_commit  = w_access & PWRITE & r_pready;

  // Input synchroniser; the last stage is the architectural input value.
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the pre-edge value of its neighbour, which is what makes a chain.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;
  assign w_hit  = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_w1c  = (w_commit && w_idx == A_IPR) ? w_wdata : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dir     <= '0;
      r_odr     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (w_commit) begin
      case (w_idx)
        A_DIR:     r_dir     <= w_wdata;
        A_ODR:     r_odr     <= w_wdata;
        A_SET:     r_odr     <= r_odr | w_wdata;
        A_CLR:     r_odr     <= r_odr & ~w_wdata;
        A_RISE_EN: r_rise_en <= w_wdata;
        A_FALL_EN: r_fall_en <= w_wdata;
        default:   ;
      endcase
    end
  end

  // OR-ing the hit in after the clear makes a same-cycle event win.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_ipr <= '0;
    else          r_ipr <= (r_ipr & ~w_w1c) | w_hit;
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      A_DIR:     w_rdata[WIDTH-1:0] = r_dir;
      A_ODR:     w_rdata[WIDTH-1:0] = r_odr;
      A_IDR:     w_rdata[WIDTH-1:0] = w_sync;
      A_RISE_EN: w_rdata[WIDTH-1:0] = r_rise_en;
      A_FALL_EN: w_rdata[WIDTH-1:0] = r_fall_en;
      A_IPR:     w_rdata[WIDTH-1:0] = r_ipr;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= w_rd_load;
      r_pslverr <= w_rd_load & PWRITE & (w_idx == A_IDR);
      if (w_rd_load && !PWRITE) r_prdata <= w_rdata;
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign gpio_out = r_odr;
  assign gpio_oe  = r_dir;
  assign irq      = |r_ipr;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench for apb_gpio_irq: an 8-bit instance for the main function
// and a 4-bit instance for width masking and mid-transfer reset.
module tb_apb_gpio_irq;

  logic        clk;
  logic        rstn8, rstn4;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic        pwrite, penable;
  logic        psel8, psel4;
  logic [31:0] prdata8, prdata4;
  logic        pready8, pready4, pslverr8, pslverr4;
  logic [7:0]  gin8, gout8, goe8;
  logic [3:0]  gin4, gout4, goe4;
  logic        irq8, irq4;

  int n_vec  = 0;
  int n_miss = 0;

  apb_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .PCLK(clk), .PRESETn(rstn8), .PADDR(paddr), .PWDATA(pwdata),
    .PWRITE(pwrite), .PENABLE(penable), .PSEL(psel8), .PRDATA(prdata8),
    .PREADY(pready8), .PSLVERR(pslverr8), .gpio_in(gin8),
    .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
  );

  apb_gpio_irq #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .PCLK(clk), .PRESETn(rstn4), .PADDR(paddr), .PWDATA(pwdata),
    .PWRITE(pwrite), .PENABLE(penable), .PSEL(psel4), .PRDATA(prdata4),
    .PREADY(pready4), .PSLVERR(pslverr4), .gpio_in(gin4),
    .gpio_out(gout4), .gpio_oe(goe4), .irq(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One APB transfer; optionally changes gpio_in (8-bit DUT) with the setup phase.
  task automatic apb_xfer(input int sel, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic chg, input logic [7:0] gin,
                          input logic exp_err, input string tag, output logic [31:0] rdata);
    @(posedge clk); #1;
    psel8   = (sel == 0);
    psel4   = (sel == 1);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    penable = 1'b0;
    if (chg) gin8 = gin;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check({tag, "_wait"}, (sel == 0) ? pready8 : pready4, 1'b0);
    @(negedge clk);
    check({tag, "_rdy"}, (sel == 0) ? pready8 : pready4, 1'b1);
    check({tag, "_err"}, (sel == 0) ? pslverr8 : pslverr4, exp_err);
    rdata = (sel == 0) ? prdata8 : prdata4;
    @(posedge clk); #1;
    psel8   = 1'b0;
    psel4   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic apb_wr(input int sel, input logic [4:0] addr, input logic [31:0] d,
                        input logic exp_err, input string tag);
    logic [31:0] dummy;
    apb_xfer(sel, 1'b1, addr, d, 1'b0, 8'h00, exp_err, tag, dummy);
  endtask

  task automatic apb_rd(input int sel, input logic [4:0] addr, input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    apb_xfer(sel, 1'b0, addr, 32'h0, 1'b0, 8'h00, 1'b0, tag, rd);
    check(tag, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    rstn8 = 1'b0; rstn4 = 1'b0;
    paddr = '0; pwdata = '0; pwrite = 1'b0; penable = 1'b0;
    psel8 = 1'b0; psel4 = 1'b0;
    gin8 = 8'h00; gin4 = 4'h0;
    idle(3);
    rstn8 = 1'b1; rstn4 = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_irq", irq8, 1'b0);
    check("rst_oe", goe8, 8'h00);
    check("rst_out", gout8, 8'h00);
    for (int i = 0; i < 8; i++) apb_rd(0, 5'(i * 4), 32'h0, $sformatf("rst_rd%0d", i));

    // Direction, output data, atomic set/clear
    apb_wr(0, 5'h00, 32'h0000_00F0, 1'b0, "wr_dir");
    apb_wr(0, 5'h04, 32'h0000_00A5, 1'b0, "wr_odr");
    apb_wr(0, 5'h0C, 32'h0000_000A, 1'b0, "wr_set");
    apb_wr(0, 5'h10, 32'h0000_0081, 1'b0, "wr_clr");
    apb_rd(0, 5'h04, 32'h0000_002E, "rd_odr");
    apb_rd(0, 5'h00, 32'h0000_00F0, "rd_dir");
    @(negedge clk);
    check("pin_out", gout8, 8'h2E);
    check("pin_oe", goe8, 8'hF0);

    // Rising edge: IDR after 2 edges, irq one edge later
    apb_wr(0, 5'h14, 32'h0000_0004, 1'b0, "wr_rise_en");
    gin8 = 8'h04;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rise_irq_t%0d", i), irq8, (i == 3));
    end
    apb_rd(0, 5'h08, 32'h0000_0004, "rise_idr");
    apb_rd(0, 5'h1C, 32'h0000_0004, "rise_ipr");
    apb_wr(0, 5'h1C, 32'h0000_0004, 1'b0, "w1c_rise");
    @(negedge clk);
    check("w1c_irq", irq8, 1'b0);
    apb_rd(0, 5'h1C, 32'h0, "w1c_ipr");

    // Falling edge pend, then a new fall on the W1C commit edge
    apb_wr(0, 5'h18, 32'h0000_0001, 1'b0, "wr_fall_en");
    gin8 = 8'h05;
    idle(4);
    @(negedge clk);
    check("bit0_rise_no_irq", irq8, 1'b0);
    idle(1);
    gin8 = 8'h04;
    idle(4);
    @(negedge clk);
    check("fall_irq", irq8, 1'b1);
    apb_rd(0, 5'h1C, 32'h0000_0001, "fall_ipr");
    idle(1);
    gin8 = 8'h05;
    idle(4);
    apb_xfer(0, 1'b1, 5'h1C, 32'h0000_0001, 1'b1, 8'h04, 1'b0, "w1c_race", rd);
    @(negedge clk);
    check("race_irq", irq8, 1'b1);
    apb_rd(0, 5'h1C, 32'h0000_0001, "race_ipr");
    apb_wr(0, 5'h1C, 32'h0000_0001, 1'b0, "w1c_fall");
    @(negedge clk);
    check("fall_cleared_irq", irq8, 1'b0);

    // IDR write error, IDR keeps tracking pins, write-only regs read 0
    apb_wr(0, 5'h08, 32'h0000_00FF, 1'b1, "wr_idr");
    apb_rd(0, 5'h08, 32'h0000_0004, "idr_after_wr");
    gin8 = 8'h3C;
    idle(3);
    apb_rd(0, 5'h08, 32'h0000_003C, "idr_track");
    apb_rd(0, 5'h0C, 32'h0, "rd_set");
    apb_rd(0, 5'h10, 32'h0, "rd_clr");
    apb_rd(0, 5'h04, 32'h0000_002E, "odr_unchanged");

    // 4-bit instance: upper bits masked
    apb_wr(1, 5'h04, 32'hFFFF_FFFF, 1'b0, "w4_wr_odr");
    apb_rd(1, 5'h04, 32'h0000_000F, "w4_rd_odr");
    @(negedge clk);
    check("w4_out", gout4, 4'hF);

    // 4-bit instance: reset during the first access cycle of a DIR write
    @(posedge clk); #1;
    psel4 = 1'b1; paddr = 5'h00; pwrite = 1'b1; pwdata = 32'h0000_000F; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rstn4 = 1'b0;
    @(negedge clk);
    check("w4_rst_pready_a", pready4, 1'b0);
    @(posedge clk); #1;
    psel4 = 1'b0; penable = 1'b0; rstn4 = 1'b1;
    @(negedge clk);
    check("w4_rst_pready_b", pready4, 1'b0);
    check("w4_rst_oe", goe4, 4'h0);
    check("w4_rst_out", gout4, 4'h0);
    apb_rd(1, 5'h00, 32'h0, "w4_dir_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
